// File: rtl/can_bit_destuff_crc_if.sv
// Bit-stream bundle between the CAN bit timing block / frame controller and the destuff+CRC stage.
// master drives sample and control strobes; slave returns delivered bits, stuff events and CRC.
interface can_bit_destuff_crc_if;
  logic        sample_point;
  logic        sampled_bit;
  logic        destuff_en;
  logic        crc_en;
  logic        crc_init;
  logic        go_error_frame;
  logic        bit_valid;
  logic        bit_out;
  logic        stuff_bit;
  logic        stuff_err;
  logic [14:0] crc_reg;
  logic        crc_zero;

  modport master (
    output sample_point, sampled_bit, destuff_en, crc_en, crc_init, go_error_frame,
    input  bit_valid, bit_out, stuff_bit, stuff_err, crc_reg, crc_zero
  );

  modport slave (
    input  sample_point, sampled_bit, destuff_en, crc_en, crc_init, go_error_frame,
    output bit_valid, bit_out, stuff_bit, stuff_err, crc_reg, crc_zero
  );
endinterface

// File: rtl/can_bit_destuff_crc.sv
// CAN receive destuffer with stuff-error detection and CRC-15 over delivered bits.
// Bit/stuff/error pulses 1 cycle after sample_point; CRC 2 cycles after; no backpressure, one sample per cycle.
module can_bit_destuff_crc #(
  parameter logic [14:0] CRC_POLY = 15'h4599
) (
  input logic                    clk,
  input logic                    rst_n,
  can_bit_destuff_crc_if.slave   rx_io
);

  typedef enum logic [1:0] {PASS, COUNT, ERROR} state_t;

  state_t      state_q;
  logic [2:0]  run_cnt_q;
  logic        last_bit_q;
  logic        bit_valid_q;
  logic        bit_out_q;
  logic        stuff_bit_q;
  logic        stuff_err_q;
  logic [14:0] crc_q;
  logic [14:0] crc_d;
  logic        crcnxt;

  // go_error_frame freezes the CRC, crc_init clears it, otherwise delivered bits shift in.
  always_comb begin
    crcnxt = bit_out_q ^ crc_q[14];
    crc_d  = crc_q;
    if (!rx_io.go_error_frame) begin
      if (rx_io.crc_init)
        crc_d = '0;
      else if (bit_valid_q && rx_io.crc_en)
        crc_d = {crc_q[13:0], 1'b0} ^ (crcnxt ? CRC_POLY : 15'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= PASS;
      run_cnt_q   <= 3'd0;
      last_bit_q  <= 1'b1;
      bit_valid_q <= 1'b0;
      bit_out_q   <= 1'b1;
      stuff_bit_q <= 1'b0;
      stuff_err_q <= 1'b0;
      crc_q       <= '0;
    end else begin
      crc_q       <= crc_d;
      bit_valid_q <= 1'b0;
      stuff_bit_q <= 1'b0;
      stuff_err_q <= 1'b0;
      if (rx_io.go_error_frame || rx_io.crc_init) begin
        run_cnt_q  <= 3'd0;
        last_bit_q <= 1'b1;
        state_q    <= rx_io.destuff_en ? COUNT : PASS;
      end else if (rx_io.sample_point && state_q != ERROR) begin
        if (!rx_io.destuff_en) begin
          state_q     <= PASS;
          run_cnt_q   <= 3'd0;
          bit_valid_q <= 1'b1;
          bit_out_q   <= rx_io.sampled_bit;
        end else begin
          // A PASS-state sample with destuff_en high is the first counted bit.
          state_q <= COUNT;
          if (run_cnt_q == 3'd5) begin
            if (rx_io.sampled_bit != last_bit_q) begin
              stuff_bit_q <= 1'b1;
              last_bit_q  <= rx_io.sampled_bit;
              run_cnt_q   <= 3'd1;
            end else begin
              stuff_err_q <= 1'b1;
              state_q     <= ERROR;
            end
          end else begin
            bit_valid_q <= 1'b1;
            bit_out_q   <= rx_io.sampled_bit;
            last_bit_q  <= rx_io.sampled_bit;
            run_cnt_q   <= (run_cnt_q != 3'd0 && rx_io.sampled_bit == last_bit_q) ?
                           run_cnt_q + 3'd1 : 3'd1;
          end
        end
      end else if (state_q == PASS && rx_io.destuff_en) begin
        state_q <= COUNT;
      end
    end
  end

  assign rx_io.bit_valid = bit_valid_q;
  assign rx_io.bit_out   = bit_out_q;
  assign rx_io.stuff_bit = stuff_bit_q;
  assign rx_io.stuff_err = stuff_err_q;
  assign rx_io.crc_reg   = crc_q;
  assign rx_io.crc_zero  = (crc_q == 15'd0);

endmodule

// File: tb/tb_can_bit_destuff_crc.sv
// Scoreboard bench for can_bit_destuff_crc: a behavioural model queues the expected outcome of every
// sample_point and a monitor pops and compares one cycle later; tasks check CRC and reset values inline.
module tb_can_bit_destuff_crc;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  can_bit_destuff_crc_if bus();

  can_bit_destuff_crc #(.CRC_POLY(15'h4599)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rx_io (bus)
  );

  typedef struct packed {
    logic [2:0] ev;   // {stuff_err, stuff_bit, bit_valid}
    logic       bo;   // bit_out after the edge
  } exp_t;

  exp_t sb_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  // reference model state
  int          m_state = 0;   // 0 PASS, 1 COUNT, 2 ERROR
  int          m_run = 0;
  logic        m_last = 1'b1;
  logic        m_bv = 1'b0;
  logic        m_bo = 1'b1;
  logic [14:0] m_crc = '0;

  // transmit-side stuffer state
  int   tx_cnt = 0;
  logic tx_last = 1'b1;

  function automatic logic [14:0] crc_step(input logic [14:0] c, input logic b);
    logic [15:0] t;
    t = {c, 1'b0};
    if (b ^ c[14]) t = t ^ 16'hC599;
    return t[14:0];
  endfunction

  // Drive one clock's worth of strobes, advance the model over the coming edge, then wait for negedge.
  task automatic cycle(input logic sp, input logic b, input logic init, input logic gef);
    exp_t e;
    bus.sample_point   = sp;
    bus.sampled_bit    = b;
    bus.crc_init       = init;
    bus.go_error_frame = gef;
    e.ev = 3'b000;
    if (!rst_n) begin
      m_state = 0; m_run = 0; m_last = 1'b1; m_bv = 1'b0; m_bo = 1'b1; m_crc = '0;
    end else begin
      if (!gef) begin
        if (init) m_crc = '0;
        else if (m_bv && bus.crc_en) m_crc = crc_step(m_crc, m_bo);
      end
      m_bv = 1'b0;
      if (gef || init) begin
        m_run = 0; m_last = 1'b1; m_state = bus.destuff_en ? 1 : 0;
      end else if (sp && m_state != 2) begin
        if (!bus.destuff_en) begin
          m_state = 0; m_run = 0; m_bv = 1'b1; m_bo = b; e.ev = 3'b001;
        end else begin
          m_state = 1;
          if (m_run == 5) begin
            if (b != m_last) begin
              e.ev = 3'b010; m_last = b; m_run = 1;
            end else begin
              e.ev = 3'b100; m_state = 2;
            end
          end else begin
            e.ev = 3'b001; m_bv = 1'b1; m_bo = b;
            if (m_run != 0 && b == m_last) m_run = m_run + 1;
            else m_run = 1;
            m_last = b;
          end
        end
      end else if (m_state == 0 && bus.destuff_en) begin
        m_state = 1;
      end
    end
    e.bo = m_bo;
    if (sp) sb_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_stuffed(input logic b);
    if (tx_cnt == 5) begin
      cycle(1'b1, ~tx_last, 1'b0, 1'b0);
      tx_last = ~tx_last;
      tx_cnt = 1;
    end
    cycle(1'b1, b, 1'b0, 1'b0);
    if (b == tx_last) tx_cnt = tx_cnt + 1;
    else tx_cnt = 1;
    tx_last = b;
  endtask

  // Monitor: every cycle following a sample_point must match the next queued outcome, other cycles are silent.
  always begin
    logic had;
    exp_t e;
    @(posedge clk);
    had = bus.sample_point;
    @(negedge clk);
    tests_run++;
    if (had) begin
      if (sb_q.size() == 0) begin
        tests_failed++;
        $display("FAIL sb_underflow: sample seen with no queued expectation");
      end else begin
        e = sb_q.pop_front();
        if ({bus.stuff_err, bus.stuff_bit, bus.bit_valid} !== e.ev ||
            bus.bit_out !== e.bo) begin
          tests_failed++;
          $display("FAIL sample_outcome: got err/stuff/valid=%b bit_out=%b, want %b bit_out=%b at %0t",
                   {bus.stuff_err, bus.stuff_bit, bus.bit_valid}, bus.bit_out, e.ev, e.bo, $time);
        end
      end
    end else if ({bus.stuff_err, bus.stuff_bit, bus.bit_valid} !== 3'b000) begin
      tests_failed++;
      $display("FAIL spurious_pulse: got err/stuff/valid=%b, want 000 at %0t",
               {bus.stuff_err, bus.stuff_bit, bus.bit_valid}, $time);
    end
  end

  task automatic test_reset;
    logic [19:0] got;
    rst_n = 1'b0;
    bus.destuff_en = 1'b0;
    bus.crc_en = 1'b0;
    idle(2);
    got = {bus.bit_valid, bus.bit_out, bus.stuff_bit, bus.stuff_err, bus.crc_reg, bus.crc_zero};
    tests_run++;
    if (got !== {1'b0, 1'b1, 1'b0, 1'b0, 15'h0000, 1'b1}) begin
      tests_failed++;
      $display("FAIL reset_state: got %h want %h", got, {1'b0, 1'b1, 1'b0, 1'b0, 15'h0000, 1'b1});
    end
    rst_n = 1'b1;
    idle(1);
  endtask

  task automatic test_destuff;
    logic [10:0] bits;
    bits = 11'b00000_1_11111;
    bus.destuff_en = 1'b1;
    bus.crc_en = 1'b0;
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 10; i >= 0; i--) cycle(1'b1, bits[i], 1'b0, 1'b0);
    idle(2);
    tests_run++;
    if (m_state != 2) begin
      tests_failed++;
      $display("FAIL destuff_err_reached: model state %0d want 2", m_state);
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    idle(1);
  endtask

  task automatic test_error;
    bus.destuff_en = 1'b1;
    bus.crc_en = 1'b0;
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, i[0], 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    idle(2);
  endtask

  task automatic test_crc_basic;
    bus.destuff_en = 1'b1;
    bus.crc_en = 1'b1;
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    idle(2);
    tests_run++;
    if (bus.crc_reg !== 15'h4599) begin
      tests_failed++;
      $display("FAIL crc_first_bit: got %h want 4599", bus.crc_reg);
    end
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    idle(2);
    tests_run++;
    if (bus.crc_reg !== 15'h4EAB) begin
      tests_failed++;
      $display("FAIL crc_second_bit: got %h want 4eab", bus.crc_reg);
    end
  endtask

  task automatic test_frame;
    logic [23:0] data;
    logic [14:0] ref_crc;
    data = 24'b0_000000_111111_0101_1_00000;
    ref_crc = '0;
    for (int i = 23; i >= 0; i--) ref_crc = crc_step(ref_crc, data[i]);
    bus.destuff_en = 1'b1;
    bus.crc_en = 1'b1;
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    tx_cnt = 0;
    tx_last = 1'b1;
    for (int i = 23; i >= 0; i--) send_stuffed(data[i]);
    idle(2);
    tests_run++;
    if (bus.crc_reg !== ref_crc) begin
      tests_failed++;
      $display("FAIL crc_stuff_transparent: got %h want %h", bus.crc_reg, ref_crc);
    end
    for (int i = 14; i >= 0; i--) send_stuffed(ref_crc[i]);
    idle(2);
    tests_run++;
    if (bus.crc_zero !== 1'b1 || bus.crc_reg !== 15'h0000) begin
      tests_failed++;
      $display("FAIL crc_zero_good_frame: got zero=%b crc=%h want 1 0000", bus.crc_zero, bus.crc_reg);
    end
  endtask

  task automatic test_pass;
    bus.destuff_en = 1'b0;
    bus.crc_en = 1'b1;
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
    idle(3);
    tests_run++;
    if (bus.bit_out !== 1'b1 || bus.crc_reg !== m_crc) begin
      tests_failed++;
      $display("FAIL pass_through: got bit_out=%b crc=%h want 1 %h", bus.bit_out, bus.crc_reg, m_crc);
    end
  endtask

  task automatic test_priority;
    logic [14:0] saved;
    saved = m_crc;
    bus.destuff_en = 1'b1;
    bus.crc_en = 1'b1;
    cycle(1'b1, 1'b0, 1'b1, 1'b1);
    idle(2);
    tests_run++;
    if (bus.crc_reg !== saved || saved === 15'h0000) begin
      tests_failed++;
      $display("FAIL priority_gef_keeps_crc: got %h want %h (nonzero)", bus.crc_reg, saved);
    end
  endtask

  task automatic test_back_to_back_reset;
    logic [19:0] got;
    bus.destuff_en = 1'b1;
    bus.crc_en = 1'b1;
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b1, i[1], 1'b0, 1'b0);
    rst_n = 1'b0;
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    got = {bus.bit_valid, bus.bit_out, bus.stuff_bit, bus.stuff_err, bus.crc_reg, bus.crc_zero};
    tests_run++;
    if (got !== {1'b0, 1'b1, 1'b0, 1'b0, 15'h0000, 1'b1}) begin
      tests_failed++;
      $display("FAIL reset_mid_stream: got %h want %h", got, {1'b0, 1'b1, 1'b0, 1'b0, 15'h0000, 1'b1});
    end
    rst_n = 1'b1;
    idle(2);
  endtask

  initial begin
    bus.sample_point = 1'b0;
    bus.sampled_bit = 1'b1;
    bus.crc_init = 1'b0;
    bus.go_error_frame = 1'b0;
    bus.destuff_en = 1'b0;
    bus.crc_en = 1'b0;
    test_reset();
    test_destuff();
    test_error();
    test_crc_basic();
    test_frame();
    test_pass();
    test_priority();
    test_back_to_back_reset();
    idle(3);
    tests_run++;
    if (sb_q.size() != 0) begin
      tests_failed++;
      $display("FAIL sb_drain: %0d expectations left, want 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/can_bit_destuff_crc.md
# can_bit_destuff_crc

Receive-side bit-stream stage that sits directly downstream of the CAN bit timing block. It consumes the one-cycle sample pulse and sampled bus value and removes stuff bits. It detects stuff errors and accumulates the CAN CRC-15 over the destuffed bits. Its outputs feed the frame-level receive state machine.

## Interface
Parameters:
- CRC_POLY, 15'h4599: CAN CRC-15 generator polynomial, x^15 term implicit.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- sample_point  in  1  one-cycle pulse; sampled_bit is valid this cycle.
- sampled_bit  in  1  bus value at the sample point; 0 = dominant.
- destuff_en  in  1  stuffed region active (SOF through CRC field).
- crc_en  in  1  accumulate CRC on delivered bits.
- crc_init  in  1  clear CRC and stuff counters; asserted before the SOF sample.
- go_error_frame  in  1  abort; clear counters and leave ERROR state.
- bit_valid  out  1  one-cycle pulse; bit_out is a delivered (non-stuff) bit.
- bit_out  out  1  delivered bit value.
- stuff_bit  out  1  one-cycle pulse; the sample was discarded as a stuff bit.
- stuff_err  out  1  one-cycle pulse; a sixth consecutive equal bit was seen.
- crc_reg  out  15  running CRC.
- crc_zero  out  1  combinational (crc_reg == 0).

## Operation
- Internal state: run_cnt (3 bits, 0..5), last_bit (1 bit), FSM in {PASS, COUNT, ERROR}.
- Event priority per cycle: go_error_frame > crc_init > sample_point.
- go_error_frame and crc_init both do the following:
  - Set run_cnt = 0 and last_bit = 1.
  - Set FSM = COUNT if destuff_en = 1, otherwise PASS.
  - crc_init additionally sets crc_reg = 0. go_error_frame leaves crc_reg unchanged.
- PASS: applies while destuff_en = 0.
  - Every sample_point produces bit_valid with bit_out = sampled_bit.
  - run_cnt is held at 0.
  - FSM moves to COUNT when destuff_en rises.
- COUNT: behaviour on a sample_point.
  - If run_cnt == 5 and sampled_bit != last_bit: the sample is a stuff bit.
    - Pulse stuff_bit; no bit_valid.
    - Set last_bit = sampled_bit and run_cnt = 1, because the stuff bit starts a new run.
  - If run_cnt == 5 and sampled_bit == last_bit: pulse stuff_err, no bit_valid, FSM moves to ERROR.
  - Otherwise: pulse bit_valid with bit_out = sampled_bit.
    - run_cnt becomes run_cnt + 1 if run_cnt != 0 and sampled_bit == last_bit; otherwise it becomes 1.
    - last_bit = sampled_bit.
  - If destuff_en = 0 at a sample_point: FSM moves to PASS and that sample is handled as PASS.
- ERROR: sample_points are ignored, so no outputs pulse. FSM leaves ERROR only on go_error_frame or crc_init.
- CRC update: on each cycle where bit_valid = 1 and crc_en = 1:
  - crcnxt = bit_out ^ crc_reg[14].
  - crc_reg = {crc_reg[13:0], 1'b0} ^ (crcnxt ? CRC_POLY : 0).
  - All arithmetic is 15 bits wide, with overflow discarded.
- Stuff bits and ERROR-state samples never update the CRC.
- After a received CRC field has been shifted in with crc_en = 1, crc_zero = 1 indicates a good frame.

## Timing
- Reset values: bit_valid = 0, bit_out = 1, stuff_bit = 0, stuff_err = 0, crc_reg = 0, crc_zero = 1; run_cnt = 0, last_bit = 1, FSM = PASS.
- bit_valid, bit_out, stuff_bit and stuff_err are registered: they assert exactly 1 cycle after sample_point and last 1 cycle.
- crc_reg updates on the edge after bit_valid is high, i.e. 2 cycles after sample_point.
- bit_out holds its value between pulses.
- sample_point in the same cycle as crc_init or go_error_frame is dropped; no output pulses.
- Back-to-back sample_points, one per cycle, must be supported without loss.
- rst_n low mid-frame returns all state to reset values on the next edge.

## Test plan
- Reset, then crc_init with destuff_en = 1, then feed bits 0,0,0,0,0,1,1 -> bit_valid pulses for bits 1-5 and bit 7; stuff_bit pulses at bit 6; the run restarts, so a further 1,1,1,1 plus a sixth 1 produces a stuff_err pulse (the stuff bit counts as the first 1 of that run).
- Six consecutive 0s after crc_init -> stuff_err pulses 1 cycle after the 6th sample_point; no bit_valid for it; later samples are silent until go_error_frame, after which counting restarts with run_cnt = 0.
- crc_en = 1, crc_init, single delivered bit 1 -> crc_reg = 0x4599; next bit 0 -> crc_reg = 0x4EAB.
- Stuff bit inserted between CRC bits -> crc_reg identical to the unstuffed stream; a frame followed by its own CRC -> crc_zero = 1.
- destuff_en = 0 with seven 1s -> seven bit_valid pulses, no stuff_err.
- crc_init, sample_point and go_error_frame all in the same cycle -> go_error_frame wins; crc_reg is unchanged and no pulse occurs. Assert rst_n low mid-stream -> all outputs at reset values.
